// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and a constant log2 helper
// used to size iteration counters.
package arith_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WORK = 1'b1;

    typedef enum logic {
        StIdle = ST_IDLE,
        StWork = ST_WORK
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/cond_neg.sv
// Conditional two's complement negation: y = neg ? -x : x, purely combinational.
module cond_neg #(
    parameter int unsigned W = 8
) (
    input  logic         neg_i,
    input  logic [W-1:0] x_i,
    output logic [W-1:0] y_o
);

    assign y_o = neg_i ? (~x_i + W'(1)) : x_i;

endmodule

// File: rtl/mul_seq_param.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with per-operation
// signed mode, optional early termination and a one-cycle done pulse.
module mul_seq_param
    import arith_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned EARLY_TERM = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [WIDTH-1:0]   a_bi,
    input  logic [WIDTH-1:0]   b_bi,
    input  logic               signed_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] y_bo
);

    localparam int unsigned CW = clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    state_e          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            neg_q, neg_d;
    logic [WIDTH-1:0] mb_q, mb_d;
    logic [PW-1:0]   ma_sh_q, ma_sh_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [PW-1:0]   y_q, y_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0] a_mag, b_mag, mb_next;
    logic [PW-1:0]    acc_sum, y_fix;
    logic             last_iter, a_neg, b_neg;

    assign a_neg = signed_i & a_bi[WIDTH-1];
    assign b_neg = signed_i & b_bi[WIDTH-1];

    cond_neg #(.W(WIDTH)) u_mag_a (
        .neg_i (a_neg),
        .x_i   (a_bi),
        .y_o   (a_mag)
    );

    cond_neg #(.W(WIDTH)) u_mag_b (
        .neg_i (b_neg),
        .x_i   (b_bi),
        .y_o   (b_mag)
    );

    cond_neg #(.W(PW)) u_fix_y (
        .neg_i (neg_q),
        .x_i   (acc_sum),
        .y_o   (y_fix)
    );

    assign acc_sum   = acc_q + (mb_q[0] ? ma_sh_q : '0);
    assign mb_next   = mb_q >> 1;
    assign last_iter = (cnt_q == CW'(WIDTH - 1)) || ((EARLY_TERM != 0) && (mb_next == '0));

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        neg_d   = neg_q;
        mb_d    = mb_q;
        ma_sh_d = ma_sh_q;
        acc_d   = acc_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StWork;
                    busy_d  = 1'b1;
                    ma_sh_d = {{WIDTH{1'b0}}, a_mag};
                    mb_d    = b_mag;
                    // A zero operand never yields a negated result.
                    neg_d   = (a_neg ^ b_neg) & (|a_bi) & (|b_bi);
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StWork: begin
                acc_d   = acc_sum;
                mb_d    = mb_next;
                ma_sh_d = ma_sh_q << 1;
                cnt_d   = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    y_d     = y_fix;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            mb_q    <= '0;
            ma_sh_q <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            neg_q   <= neg_d;
            mb_q    <= mb_d;
            ma_sh_q <= ma_sh_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign y_bo   = y_q;

endmodule

// File: tb/tb_mul_seq_param.sv
// Directed and randomised checks of mul_seq_param: W=8 plain, W=8 early-terminate,
// and W=16 instances share one clock and reset.
module tb_mul_seq_param;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    // W=8, EARLY_TERM=0
    logic [7:0]  a0 = '0, b0 = '0;
    logic        s0 = 1'b0, st0 = 1'b0;
    logic        busy0, done0;
    logic [15:0] y0;
    // W=8, EARLY_TERM=1
    logic [7:0]  a1 = '0, b1 = '0;
    logic        s1 = 1'b0, st1 = 1'b0;
    logic        busy1, done1;
    logic [15:0] y1;
    // W=16, EARLY_TERM=0
    logic [15:0] a2 = '0, b2 = '0;
    logic        s2 = 1'b0, st2 = 1'b0;
    logic        busy2, done2;
    logic [31:0] y2;

    always #5 clk = ~clk;

    mul_seq_param #(.WIDTH(8), .EARLY_TERM(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .a_bi(a0), .b_bi(b0), .signed_i(s0), .start_i(st0),
        .busy_o(busy0), .done_o(done0), .y_bo(y0)
    );

    mul_seq_param #(.WIDTH(8), .EARLY_TERM(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .a_bi(a1), .b_bi(b1), .signed_i(s1), .start_i(st1),
        .busy_o(busy1), .done_o(done1), .y_bo(y1)
    );

    mul_seq_param #(.WIDTH(16), .EARLY_TERM(0)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .a_bi(a2), .b_bi(b2), .signed_i(s2), .start_i(st2),
        .busy_o(busy2), .done_o(done2), .y_bo(y2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start one op from the current (idle or done) cycle and wait for done.
    task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int nbusy, output logic [15:0] y, output logic ok);
        a0 = a; b0 = b; s0 = s; st0 = 1'b1;
        step();
        st0 = 1'b0;
        nbusy = 0; ok = 1'b0; y = '0;
        for (int i = 0; i < 40; i++) begin
            if (done0) begin
                ok = 1'b1;
                y  = y0;
                break;
            end
            if (busy0) nbusy++;
            step();
        end
    endtask

    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int nbusy, output logic [15:0] y, output logic ok);
        a1 = a; b1 = b; s1 = s; st1 = 1'b1;
        step();
        st1 = 1'b0;
        nbusy = 0; ok = 1'b0; y = '0;
        for (int i = 0; i < 40; i++) begin
            if (done1) begin
                ok = 1'b1;
                y  = y1;
                break;
            end
            if (busy1) nbusy++;
            step();
        end
    endtask

    task automatic run2(input logic [15:0] a, input logic [15:0] b, input logic s,
                        output int nbusy, output logic [31:0] y, output logic ok);
        a2 = a; b2 = b; s2 = s; st2 = 1'b1;
        step();
        st2 = 1'b0;
        nbusy = 0; ok = 1'b0; y = '0;
        for (int i = 0; i < 60; i++) begin
            if (done2) begin
                ok = 1'b1;
                y  = y2;
                break;
            end
            if (busy2) nbusy++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_tests++;
        if ({busy0, done0, y0} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_dut0: busy=%b done=%b y=%h, want 0 0 0000", busy0, done0, y0);
        end
        n_tests++;
        if ({busy1, done1, y1} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: busy=%b done=%b y=%h, want 0 0 0000", busy1, done1, y1);
        end
        n_tests++;
        if ({busy2, done2, y2} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_dut2: busy=%b done=%b y=%h, want 0 0 0", busy2, done2, y2);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_unsigned_max();
        int nb; logic [15:0] y; logic ok;
        run0(8'd255, 8'd255, 1'b0, nb, y, ok);
        n_tests++;
        if (ok !== 1'b1 || nb != 8) begin
            n_fail++;
            $display("FAIL umax_latency: done=%b busy_cycles=%0d, want 1 8", ok, nb);
        end
        n_tests++;
        if (y !== 16'hFE01) begin
            n_fail++;
            $display("FAIL umax_product: y=%h, want fe01", y);
        end
        step();
        n_tests++;
        if (done0 !== 1'b0 || y0 !== 16'hFE01) begin
            n_fail++;
            $display("FAIL umax_pulse_hold: done=%b y=%h, want 0 fe01", done0, y0);
        end
    endtask

    task automatic test_signed();
        logic [7:0]  va [3] = '{8'h80, 8'hFD, 8'h7F};
        logic [7:0]  vb [3] = '{8'h80, 8'h05, 8'h80};
        logic [15:0] ve [3] = '{16'h4000, 16'hFFF1, 16'hC080};
        int nb; logic [15:0] y; logic ok;
        for (int i = 0; i < 3; i++) begin
            run0(va[i], vb[i], 1'b1, nb, y, ok);
            n_tests++;
            if (ok !== 1'b1 || y !== ve[i]) begin
                n_fail++;
                $display("FAIL signed_%0d: done=%b y=%h, want 1 %h", i, ok, y, ve[i]);
            end
        end
    endtask

    task automatic test_ignore_busy_start();
        int ndone;
        ndone = 0;
        a0 = 8'd7; b0 = 8'd9; s0 = 1'b0; st0 = 1'b1;
        step();                          // k+1
        st0 = 1'b0;
        step();                          // k+2
        a0 = 8'd1; b0 = 8'd1; st0 = 1'b1;
        step();                          // k+3 edge sees start while busy
        st0 = 1'b0; a0 = 8'hAA; b0 = 8'h55;
        for (int i = 0; i < 16; i++) begin
            if (done0) ndone++;
            step();
        end
        n_tests++;
        if (ndone != 1 || y0 !== 16'd63) begin
            n_fail++;
            $display("FAIL ignore_busy_start: dones=%0d y=%0d, want 1 63", ndone, y0);
        end
    endtask

    task automatic test_reset_mid_op();
        int ndone; int nb; logic [15:0] y; logic ok;
        ndone = 0;
        a0 = 8'd200; b0 = 8'd3; s0 = 1'b0; st0 = 1'b1;
        step();                          // k+1
        st0 = 1'b0;
        step();                          // k+2
        step();                          // k+3
        rst = 1'b1;
        step();                          // reset sampled at edge k+4
        rst = 1'b0;
        n_tests++;
        if (busy0 !== 1'b0 || y0 !== 16'd0 || done0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_op: busy=%b y=%h done=%b, want 0 0000 0", busy0, y0, done0);
        end
        for (int i = 0; i < 12; i++) begin
            if (done0) ndone++;
            step();
        end
        n_tests++;
        if (ndone != 0) begin
            n_fail++;
            $display("FAIL reset_no_done: dones=%0d, want 0", ndone);
        end
        run0(8'd12, 8'd11, 1'b0, nb, y, ok);
        n_tests++;
        if (ok !== 1'b1 || y !== 16'd132) begin
            n_fail++;
            $display("FAIL after_reset: done=%b y=%0d, want 1 132", ok, y);
        end
    endtask

    task automatic test_early_term();
        logic [7:0]  va [3] = '{8'h5A, 8'h33, 8'h03};
        logic [7:0]  vb [3] = '{8'h01, 8'h00, 8'h80};
        logic [15:0] ve [3] = '{16'h005A, 16'h0000, 16'h0180};
        int          vn [3] = '{1, 1, 8};
        int nb; logic [15:0] y; logic ok;
        for (int i = 0; i < 3; i++) begin
            run1(va[i], vb[i], 1'b0, nb, y, ok);
            n_tests++;
            if (ok !== 1'b1 || nb != vn[i] || y !== ve[i]) begin
                n_fail++;
                $display("FAIL early_term_%0d: done=%b busy_cycles=%0d y=%h, want 1 %0d %h",
                         i, ok, nb, y, vn[i], ve[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int nb; logic [15:0] y; logic ok;
        run0(8'd13, 8'd17, 1'b0, nb, y, ok);
        n_tests++;
        if (ok !== 1'b1 || y !== 16'd221) begin
            n_fail++;
            $display("FAIL b2b_first: done=%b y=%0d, want 1 221", ok, y);
        end
        // Issued in the done cycle; a full 8 busy cycles proves no idle gap.
        run0(8'd250, 8'd6, 1'b0, nb, y, ok);
        n_tests++;
        if (ok !== 1'b1 || nb != 8 || y !== 16'd1500) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b busy_cycles=%0d y=%0d, want 1 8 1500", ok, nb, y);
        end
    endtask

    task automatic test_random();
        int nb; logic ok;
        logic [7:0] a, b; logic s;
        logic [15:0] y, ax, bx, e;
        logic [15:0] c, d;
        logic [31:0] y32, cx, dx, e32;
        for (int i = 0; i < 2000; i++) begin
            a = 8'($urandom); b = 8'($urandom); s = 1'($urandom);
            ax = s ? {{8{a[7]}}, a} : {8'd0, a};
            bx = s ? {{8{b[7]}}, b} : {8'd0, b};
            e  = ax * bx;
            run0(a, b, s, nb, y, ok);
            n_tests++;
            if (ok !== 1'b1 || y !== e) begin
                n_fail++;
                $display("FAIL rand_w8: a=%h b=%h s=%b y=%h, want %h", a, b, s, y, e);
            end
        end
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom); b = 8'($urandom >> ($urandom_range(0, 7))); s = 1'($urandom);
            ax = s ? {{8{a[7]}}, a} : {8'd0, a};
            bx = s ? {{8{b[7]}}, b} : {8'd0, b};
            e  = ax * bx;
            run1(a, b, s, nb, y, ok);
            n_tests++;
            if (ok !== 1'b1 || y !== e) begin
                n_fail++;
                $display("FAIL rand_w8_et: a=%h b=%h s=%b y=%h, want %h", a, b, s, y, e);
            end
        end
        for (int i = 0; i < 1500; i++) begin
            c = 16'($urandom); d = 16'($urandom); s = 1'($urandom);
            cx  = s ? {{16{c[15]}}, c} : {16'd0, c};
            dx  = s ? {{16{d[15]}}, d} : {16'd0, d};
            e32 = cx * dx;
            run2(c, d, s, nb, y32, ok);
            n_tests++;
            if (ok !== 1'b1 || y32 !== e32) begin
                n_fail++;
                $display("FAIL rand_w16: a=%h b=%h s=%b y=%h, want %h", c, d, s, y32, e32);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_ignore_busy_start();
        test_reset_mid_op();
        test_early_term();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
